// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family:
// requester count, select width, FSM encoding and index-to-one-hot.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: the first set request at or
// after ptr (wrapping mod 4) wins.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   win_idx,
  output logic               any
);

  // rot[k] is the request that sits k places after the pointer
  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [SEL_W-1:0] src;
      assign src     = ptr + SEL_W'(gi);
      assign rot[gi] = req[src];
    end
  endgenerate

  always_comb begin
    off = '0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
  end

  assign win_idx = ptr + off;
  assign any     = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 4:1 datapath mux: grants one
// requester at a time, registers its beats onto y and bounds each grant's length.
module mux_rr_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic [DATA_W-1:0]  data_a,
  input  logic [DATA_W-1:0]  data_b,
  input  logic [DATA_W-1:0]  data_c,
  input  logic [DATA_W-1:0]  data_d,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [DATA_W-1:0]  y,
  output logic               valid,
  output logic               busy
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  arb_state_t         state_reg, state_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [7:0]         hold_reg, hold_next;
  logic [DATA_W-1:0]  y_reg, y_next;
  logic               valid_reg, valid_next;

  logic [SEL_W-1:0]   win_idx;
  logic               win_any;
  logic [DATA_W-1:0]  sel_data;
  logic               owner_req;
  logic               owner_last;
  logic [7:0]         hold_inc;

  rr_pick u_pick (
    .req     (req),
    .ptr     (ptr_reg),
    .win_idx (win_idx),
    .any     (win_any)
  );

  always_comb begin
    case (sel_reg)
      2'd0:    sel_data = data_a;
      2'd1:    sel_data = data_b;
      2'd2:    sel_data = data_c;
      default: sel_data = data_d;
    endcase
  end

  // sel_reg doubles as the owner index; it only moves on IDLE->GRANT
  assign owner_req  = req[sel_reg];
  assign owner_last = last[sel_reg];
  assign hold_inc   = (hold_reg == 8'hFF) ? hold_reg : hold_reg + 8'd1;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    gnt_next   = gnt_reg;
    hold_next  = hold_reg;
    y_next     = y_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
        if (win_any) begin
          sel_next   = win_idx;
          gnt_next   = idx_to_onehot(win_idx);
          hold_next  = 8'd0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (owner_req) begin
          y_next     = sel_data;
          valid_next = 1'b1;
          hold_next  = hold_inc;
          if (owner_last || (hold_inc >= HOLD_LIM)) begin
            gnt_next   = '0;
            state_next = RELEASE;
          end
        end else begin
          valid_next = 1'b0;
          gnt_next   = '0;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        gnt_next   = '0;
        valid_next = 1'b0;
        ptr_next   = sel_reg + 2'd1;
        state_next = IDLE;
      end
      default: begin
        gnt_next   = '0;
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      sel_reg   <= '0;
      gnt_reg   <= '0;
      hold_reg  <= '0;
      y_reg     <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      gnt_reg   <= gnt_next;
      hold_reg  <= hold_next;
      y_reg     <= y_next;
      valid_reg <= valid_next;
    end
  end

  assign gnt   = gnt_reg;
  assign sel   = sel_reg;
  assign y     = y_reg;
  assign valid = valid_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the shared 4:1 32-bit datapath mux. Four requesters compete for one downstream resource, such as the memory/writeback bus. The block grants one requester at a time and drives the mux `sel` code for it. It registers the selected word with a valid flag and enforces a bounded hold time so no requester can starve the others.

## Interface
Parameters:
- `DATA_W`, 32, width of each data input and of `y`.
- `MAX_HOLD`, 16, maximum cycles one grant may be held; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  4  request per requester; bit i maps to mux input i (A=0, B=1, C=2, D=3).
- `last`  in  4  requester i marks its final beat; only meaningful while it is granted.
- `data_a`, `data_b`, `data_c`, `data_d`  in  DATA_W each  requester data words.
- `gnt`  out  4  one-hot grant, or all zero when no requester is granted.
- `sel`  out  2  mux select code of the current owner; holds its last value when idle.
- `y`  out  DATA_W  registered selected data.
- `valid`  out  1  `y` carries a beat accepted in the previous cycle.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: no grant. If `req`≠0, pick a winner by round-robin, load `sel`, set `gnt` one-hot and clear the hold counter. Go to GRANT.
  - GRANT: the owner is fixed. A cycle with `req[owner]`=1 is a beat: `y` ← selected data, `valid` ← 1, hold counter +1. A cycle with `req[owner]`=0 is not a beat: `valid` ← 0. Leave GRANT for RELEASE on the first of:
    - (a) a beat with `last[owner]`=1;
    - (b) `req[owner]`=0;
    - (c) a beat that brings the hold counter to `MAX_HOLD`.
  - RELEASE: `gnt` ← 0, `valid` ← 0, priority pointer ← owner+1 mod 4. Go to IDLE.
- Round-robin: search order is ptr, ptr+1, ptr+2, ptr+3 mod 4, and the first set `req` bit wins. The pointer resets to 0, so A has first priority after reset.
- The hold counter is 8 bits wide and saturates; it does not wrap.
- `last` or `req` bits of non-owners are ignored while in GRANT.
- A forced release (c) does not clear the requester's pending work. If it still requests, it competes again after the other requesters.

## Timing
- Reset values: `gnt`=0, `sel`=0, `y`=0, `valid`=0, `busy`=0, pointer=0, state IDLE. Reset applied mid-grant takes effect at the next edge and drops `gnt` without a RELEASE cycle.
- Grant latency: `req` first seen in IDLE at edge k gives `gnt` and `sel` valid after edge k.
- Data latency: a beat's data sampled at edge n appears on `y` with `valid`=1 after edge n, and is held until the next beat.
- Turnaround: the GRANT→RELEASE→IDLE→GRANT path leaves two cycles with `gnt`=0 between different owners. This is fixed; there is no back-to-back grant.
- `sel` changes only on the IDLE→GRANT edge, so the mux output is stable for the whole grant.
- Simultaneous requests are resolved only by the pointer. No requester has fixed priority beyond what the pointer gives.
- `MAX_HOLD`=1: every grant lasts exactly one beat.

## Structure
- Shared package `arb_pkg`:
  - `NUM_REQ`=4 and `SEL_W`=2.
  - FSM state enum: IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10.
  - The index→one-hot function.
- Sub-module `rr_pick`: combinational; inputs `req[3:0]` and `ptr[1:0]`; outputs `win_idx[1:0]` and `any`. It is reusable by other arbiters.
- Top level contains the FSM, the pointer, the hold counter and the output registers. It may instantiate the existing 4:1 mux for data selection, or use an equivalent case on `sel`.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles with `req`=4'hF, then release → no grant during reset. `gnt`=4'b0001, `sel`=0 one cycle after the first IDLE.
- Single burst: `req`=4'b0100, `data_c`=32'hDEAD_0000+beat, `last` on beat 3 → `valid` high for 3 cycles and `y` = 32'hDEAD_0000, 1, 2. `gnt` drops after the 3rd beat. Next grant search starts at D.
- Rotation: `req`=4'hF held, 1-beat bursts → grant order A, B, C, D, A with exactly 2 idle-grant cycles between grants.
- Hold limit: `MAX_HOLD`=4, `req`=4'b0011, A never asserts `last` → A is released after 4 beats and B is granted next. A regains the grant only after B releases.
- Owner drop: B is granted, then `req[1]` falls after 2 beats → no further `valid`, RELEASE follows immediately, and the pointer moves to C.
- Mid-grant reset: assert `rst_n`=0 during beat 2 of a D burst → next cycle `gnt`=0, `valid`=0, `y`=0, pointer=0.
